ro_freq_meter: RTL
==================

// Module: ro_freq_meter
// PURPOSE
//  Parametrised successor to the fixed 16:1 oscillator output mux. Selects one of N_CH free-running
//  ring-oscillator outputs and enables it. After a settle period, it counts the oscillator's rising
//  edges over a programmable gate window of wb_clk_i cycles. It reports the count with a valid pulse,
//  in single-shot or back-to-back continuous mode.
//  Sits in user_project_wrapper between the oscillator macros and the io/wishbone control logic.
// PARAMETERS
//  N_CH       16  number of oscillator inputs; SEL_W = $clog2(N_CH) (localparam, min 1)
//  CNT_W      24  edge-counter / result width
//  GATE_W     20  gate-window length width
//  SETTLE_CYC 64  cycles ro_enable is held before the window opens (>=2, covers synchroniser fill)
// PORTS
//  wb_clk_i     in   1      sole clock, rising edge
//  wb_rst_ni    in   1      asynchronous, active-low reset
//  ro_in        in   N_CH   raw oscillator outputs, asynchronous to wb_clk_i
//  ch_sel       in   SEL_W  channel to measure, sampled only on accepted start
//  start        in   1      request; accepted only in IDLE
//  cont         in   1      1 = continuous windows, 0 = single shot; sampled with start
//  gate_cycles  in   GATE_W window length in cycles; 0 treated as 1; sampled with start
//  abort        in   1      stop any measurement; highest priority after reset
//  ro_enable    out  1      oscillator start/enable (drives macro 'start')
//  busy         out  1      1 in SETTLE or MEASURE
//  result       out  CNT_W  edge count of last completed window
//  result_ch    out  SEL_W  channel that result belongs to
//  valid        out  1      one-cycle pulse when result/result_ch update
//  ovf          out  1      sticky: counter saturated in the last completed window
// BEHAVIOUR
//  Reset (wb_rst_ni=0, async): state IDLE; ro_enable, busy, valid, ovf = 0; result, result_ch = 0;
//   synchroniser, edge, gate and settle counters = 0. Outputs go to 0 without a clock edge.
//  Input path: ro_in[ch_q] -> 2-flop synchroniser -> rising-edge detect (s2 & ~s3).
//   ch_q >= N_CH selects constant 0.
//   Accuracy holds only for f_ro < f_clk/2; faster oscillators undercount (no aliasing check).
//  FSM: IDLE, SETTLE, MEASURE.
//   IDLE: on start=1 -> latch ch_q=ch_sel, g_q=max(gate_cycles,1), cont_q=cont;
//    clear ovf; set ro_enable=1, busy=1; settle_cnt=0; -> SETTLE.
//   SETTLE: settle_cnt increments each cycle. Edges are ignored.
//    When settle_cnt==SETTLE_CYC-1 -> MEASURE with edge_cnt=0 and gate_cnt=0.
//   MEASURE: gate_cnt increments each cycle. Each detected edge increments edge_cnt, saturating at
//    2^CNT_W-1; an increment attempted while saturated sets ovf_int.
//    The window is exactly g_q cycles. On its last cycle (gate_cnt==g_q-1):
//    - result <= edge_cnt + edge_this_cycle (saturating); result_ch <= ch_q; ovf <= ovf_int.
//    - valid=1 on the next cycle.
//    - If cont_q: stay in MEASURE; counters restart the next cycle with no dead cycle, so no edge is
//      lost or double-counted across windows.
//    - Else: -> IDLE; ro_enable=0 and busy=0 on the next cycle.
//  Latency: start accepted at edge T0 -> first valid high in the cycle after edge T0+SETTLE_CYC+g_q.
//  start while busy: ignored. ch_sel/cont/gate_cycles changes while busy: ignored.
//   Continuous mode runs until abort.
//  abort=1 in any state: -> IDLE next edge; ro_enable=0, busy=0; no valid for the partial window;
//   result/result_ch/ovf keep their previous values. abort and start in the same IDLE cycle: start ignored.
//  Synchroniser delay shifts the window 2 cycles relative to the FSM. This is accepted; the
//   window-to-window count is still exact in continuous mode.
//  valid is never high for 2 consecutive cycles except in continuous mode with g_q=1.
// TESTING
//  1 N_CH=16, ch3 period 10 clk, sel=3, gate=1000, single -> one valid, result in {99,100,101},
//    result_ch=3, ro_enable/busy low next cycle.
//  2 cont=1, gate=200, period 8, 5 windows -> each result 25+-1; sum over windows = bench edge count.
//  3 CNT_W=8, period 4, gate=2000 -> result=255, ovf=1; next start clears ovf at acceptance.
//  4 abort at MEASURE cycle 50 -> busy=0 next cycle, no valid, result unchanged from test 1.
//  5 wb_rst_ni low mid-MEASURE, clock stopped -> all outputs 0 immediately; no valid after release.
//  6 N_CH=12: sel=14 -> result=0 valid; gate=0 -> window 1 cycle; start during busy -> no effect.

Source files
------------

// File: rtl/ro_freq_meter.sv
// ro_freq_meter
//   Ring-oscillator frequency meter. Selects one of N_CH free-running oscillator outputs and
//   enables it. After a settle period it counts the oscillator's rising edges over a
//   programmable window of wb_clk_i cycles. Results are reported with a one-cycle valid pulse,
//   either once (single shot) or window after window (continuous) until aborted.
//
// Ports
//   wb_clk_i     in   1       sole clock, rising edge
//   wb_rst_ni    in   1       asynchronous active-low reset
//   ro_in        in   N_CH    raw oscillator outputs (asynchronous to wb_clk_i)
//   ch_sel       in   SEL_W   channel to measure, sampled on an accepted start
//   start        in   1       measurement request, accepted only when idle
//   cont         in   1       1 = continuous windows, 0 = single shot (sampled with start)
//   gate_cycles  in   GATE_W  window length in cycles, 0 behaves as 1 (sampled with start)
//   abort        in   1       stop any measurement, no result for the partial window
//   ro_enable    out  1       oscillator enable
//   busy         out  1       high while settling or measuring
//   result       out  CNT_W   saturated edge count of the last completed window
//   result_ch    out  SEL_W   channel that result belongs to
//   valid        out  1       one-cycle pulse when result/result_ch update
//   ovf          out  1       counter saturated in the last completed window
module ro_freq_meter #(
  parameter  int N_CH       = 16,
  parameter  int CNT_W      = 24,
  parameter  int GATE_W     = 20,
  parameter  int SETTLE_CYC = 64,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [N_CH-1:0]   ro_in,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic              start,
  input  logic              cont,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              abort,
  output logic              ro_enable,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic [SEL_W-1:0]  result_ch,
  output logic              valid,
  output logic              ovf
);

  localparam int SET_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t              state_r;
  logic [SEL_W-1:0]    ch_r;
  logic [GATE_W-1:0]   gate_r;
  logic                cont_r;
  logic [SET_W-1:0]    settle_cnt_r;
  logic [GATE_W-1:0]   gate_cnt_r;
  logic [CNT_W-1:0]    edge_cnt_r;
  logic                ovf_int_r;
  logic                sync1_r;
  logic                sync2_r;
  logic                sync3_r;

  logic                ro_sel_s;
  logic                edge_s;
  logic [CNT_W-1:0]    edge_next_s;
  logic                ovf_hit_s;
  logic                gate_last_s;

  // Channel mux in front of the synchroniser; out-of-range channels read as a constant 0
  always_comb begin
    ro_sel_s = 1'b0;
    if ({{(32-SEL_W){1'b0}}, ch_r} < 32'(N_CH)) begin
      ro_sel_s = ro_in[ch_r];
    end else begin
      ro_sel_s = 1'b0;
    end
  end

  // Two-flop synchroniser plus one history flop for rising-edge detection
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= ro_sel_s;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Saturating edge count including this cycle's edge, and the last-window-cycle flag
  always_comb begin
    edge_s      = sync2_r & ~sync3_r;
    edge_next_s = edge_cnt_r;
    ovf_hit_s   = 1'b0;
    if (edge_s && (edge_cnt_r == CNT_MAX)) begin
      ovf_hit_s = 1'b1;
    end else if (edge_s) begin
      edge_next_s = edge_cnt_r + CNT_W'(1);
    end else begin
      edge_next_s = edge_cnt_r;
    end
    gate_last_s = (gate_cnt_r == (gate_r - GATE_W'(1)));
  end

  // Measurement FSM with registered outputs; abort overrides every state
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r      <= IDLE;
      ch_r         <= '0;
      gate_r       <= GATE_W'(1);
      cont_r       <= 1'b0;
      settle_cnt_r <= '0;
      gate_cnt_r   <= '0;
      edge_cnt_r   <= '0;
      ovf_int_r    <= 1'b0;
      ro_enable    <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_ch    <= '0;
      valid        <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (abort) begin
        state_r   <= IDLE;
        ro_enable <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              ch_r         <= ch_sel;
              gate_r       <= (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
              cont_r       <= cont;
              ovf          <= 1'b0;
              ro_enable    <= 1'b1;
              busy         <= 1'b1;
              settle_cnt_r <= '0;
              state_r      <= SETTLE;
            end
          end
          SETTLE: begin
            // Edges seen while settling are discarded; the count starts clean on entry
            if (settle_cnt_r == SET_LAST) begin
              edge_cnt_r <= '0;
              gate_cnt_r <= '0;
              ovf_int_r  <= 1'b0;
              state_r    <= MEASURE;
            end else begin
              settle_cnt_r <= settle_cnt_r + SET_W'(1);
            end
          end
          MEASURE: begin
            if (gate_last_s) begin
              // The edge of the last window cycle belongs to this window, not the next
              result    <= edge_next_s;
              result_ch <= ch_r;
              ovf       <= ovf_int_r | ovf_hit_s;
              valid     <= 1'b1;
              if (cont_r) begin
                edge_cnt_r <= '0;
                gate_cnt_r <= '0;
                ovf_int_r  <= 1'b0;
              end else begin
                state_r   <= IDLE;
                ro_enable <= 1'b0;
                busy      <= 1'b0;
              end
            end else begin
              gate_cnt_r <= gate_cnt_r + GATE_W'(1);
              edge_cnt_r <= edge_next_s;
              ovf_int_r  <= ovf_int_r | ovf_hit_s;
            end
          end
          default: begin
            state_r   <= IDLE;
            ro_enable <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
